// File: rtl/alu_control_unit.sv
// rtl/alu_control_unit.sv - multi-cycle fetch/decode/execute controller for a 16-bit accumulator datapath
// Owns PC, IR, MDR and ACC; drives one shared instruction/data memory port and an external ALU.
module alu_control_unit #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 12,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] alu_num1,
  output logic [DATA_W-1:0] alu_num2,
  output logic [3:0]        alu_opcode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] acc_out
);

  localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_PC);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_NOT   = 4'h6;
  localparam logic [3:0] OP_LOAD  = 4'h7;
  localparam logic [3:0] OP_STORE = 4'h8;
  localparam logic [3:0] OP_JMP   = 4'h9;
  localparam logic [3:0] OP_JZ    = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_HALTED
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;
  logic [DATA_W-1:0] mdr;
  logic [DATA_W-1:0] acc;
  logic              illegal_q;

  logic [3:0]        op;
  logic [ADDR_W-1:0] operand;
  logic              op_is_alu2;
  logic              op_is_bad;
  logic              start_ok;

  assign op      = ir[DATA_W-1:DATA_W-4];
  assign operand = ir[ADDR_W-1:0];

  assign op_is_alu2 = (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
                      (op == OP_OR)  || (op == OP_XOR);
  // B-E are the only undefined encodings
  assign op_is_bad  = (op >= 4'hB) && (op <= 4'hE);
  assign start_ok   = start && ((state == S_IDLE) || (state == S_HALTED));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALTED: begin
        if (start) state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (mem_ack) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (op_is_alu2 || (op == OP_LOAD)) state_nxt = S_READ;
        else if (op == OP_NOT)             state_nxt = S_EXEC;
        else if (op == OP_STORE)           state_nxt = S_WRITE;
        else if ((op == OP_NOP) || (op == OP_JMP) || (op == OP_JZ))
                                           state_nxt = S_FETCH;
        else                               state_nxt = S_HALTED;
      end
      S_READ: begin
        if (mem_ack) state_nxt = (op == OP_LOAD) ? S_FETCH : S_EXEC;
      end
      S_EXEC: begin
        state_nxt = S_FETCH;
      end
      S_WRITE: begin
        if (mem_ack) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Architectural registers; a jump in DECODE overrides the FETCH increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RST_PC;
      ir        <= '0;
      mdr       <= '0;
      acc       <= '0;
      illegal_q <= 1'b0;
    end else begin
      if (start_ok) begin
        pc        <= RST_PC;
        illegal_q <= 1'b0;
      end
      if ((state == S_FETCH) && mem_ack) begin
        ir <= mem_rdata;
        pc <= pc + 1'b1;
      end
      if (state == S_DECODE) begin
        if (op == OP_JMP) pc <= operand;
        if ((op == OP_JZ) && (acc == '0)) pc <= operand;
        if (op_is_bad) illegal_q <= 1'b1;
      end
      if ((state == S_READ) && mem_ack) begin
        if (op == OP_LOAD) acc <= mem_rdata;
        else               mdr <= mem_rdata;
      end
      if (state == S_EXEC) acc <= alu_result;
    end
  end

  // Port outputs decode from state only, so reset drops mem_req asynchronously
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    alu_opcode = 4'h0;
    busy       = 1'b1;
    halted     = 1'b0;
    case (state)
      S_IDLE: busy = 1'b0;
      S_HALTED: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc;
      end
      S_READ: begin
        mem_req  = 1'b1;
        mem_addr = operand;
      end
      S_WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = operand;
        mem_wdata = acc;
      end
      S_EXEC: alu_opcode = op;
      default: ;
    endcase
  end

  assign alu_num1 = acc;
  assign alu_num2 = mdr;
  assign illegal  = illegal_q;
  assign pc_out   = pc;
  assign acc_out  = acc;

endmodule

// File: tb/tb_alu_control_unit.sv
// tb/tb_alu_control_unit.sv - directed self-checking bench for alu_control_unit
// Bench-side memory with optional wait states, stray acks and a blocked address; bench-side ALU.
module tb_alu_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mem_req;
  logic        mem_we;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] alu_num1;
  logic [15:0] alu_num2;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_result;
  logic        busy;
  logic        halted;
  logic        illegal;
  logic [11:0] pc_out;
  logic [15:0] acc_out;

  int checks   = 0;
  int failures = 0;

  logic [15:0] mem [0:4095];
  int          max_wait;
  int          wait_left;
  bit          stray;
  bit          block_en;
  logic [11:0] block_addr;
  int          stab_err;
  bit          pending;
  logic [11:0] p_addr;
  logic        p_we;
  logic [15:0] p_wdata;

  always #5 clk = ~clk;

  alu_control_unit #(.DATA_W(16), .ADDR_W(12), .RESET_PC(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .alu_num1   (alu_num1),
    .alu_num2   (alu_num2),
    .alu_opcode (alu_opcode),
    .alu_result (alu_result),
    .busy       (busy),
    .halted     (halted),
    .illegal    (illegal),
    .pc_out     (pc_out),
    .acc_out    (acc_out)
  );

  always_comb begin
    alu_result = 16'h0000;
    case (alu_opcode)
      4'h1: alu_result = alu_num1 + alu_num2;
      4'h2: alu_result = alu_num1 - alu_num2;
      4'h3: alu_result = alu_num1 & alu_num2;
      4'h4: alu_result = alu_num1 | alu_num2;
      4'h5: alu_result = alu_num1 ^ alu_num2;
      4'h6: alu_result = ~alu_num1;
      default: alu_result = 16'h0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responds on the falling edge so the DUT sees ack/rdata at the next rising edge
  task automatic mem_proc();
    forever begin
      @(negedge clk);
      mem_ack   = 1'b0;
      mem_rdata = 16'h0000;
      if (mem_req) begin
        if (pending && ((mem_addr !== p_addr) || (mem_we !== p_we) ||
                        (mem_we && (mem_wdata !== p_wdata))))
          stab_err++;
        if ((wait_left == 0) && !(block_en && (mem_addr == block_addr))) begin
          mem_ack = 1'b1;
          if (mem_we) mem[mem_addr] = mem_wdata;
          else        mem_rdata = mem[mem_addr];
          pending   = 1'b0;
          wait_left = int'($urandom_range(0, max_wait));
        end else begin
          if (wait_left != 0) wait_left--;
          pending = 1'b1;
          p_addr  = mem_addr;
          p_we    = mem_we;
          p_wdata = mem_wdata;
        end
      end else begin
        pending = 1'b0;
        if (stray) begin
          mem_ack   = 1'b1;
          mem_rdata = 16'hDEAD;
        end
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at the negedge right after pulse_start; counts busy cycles until HALTED
  task automatic run(input string tag, output int cyc);
    bit done;
    cyc  = 0;
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (busy) cyc++;
      else if (halted) begin
        done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_halt_reached"}, {31'd0, done}, 32'd1);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  initial begin
    int          cyc;
    bit          found;
    logic [3:0]  t2_op  [5];
    logic [15:0] t2_exp [5];
    t2_op  = '{4'h2, 4'h3, 4'h4, 4'h5, 4'h6};
    t2_exp = '{16'h0006, 16'h0001, 16'h000B, 16'h000A, 16'hFFF6};

    rst_n      = 1'b0;
    start      = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = 16'h0000;
    max_wait   = 0;
    wait_left  = 0;
    stray      = 1'b0;
    block_en   = 1'b0;
    block_addr = 12'h000;
    stab_err   = 0;
    pending    = 1'b0;
    p_addr     = 12'h000;
    p_we       = 1'b0;
    p_wdata    = 16'h0000;
    clear_mem();
    fork
      mem_proc();
    join_none

    repeat (3) @(negedge clk);
    check("rst_mem_req", {31'd0, mem_req}, 32'd0);
    check("rst_mem_addr", {20'd0, mem_addr}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    check("rst_pc", {20'd0, pc_out}, 32'd0);
    check("rst_acc", {16'd0, acc_out}, 32'd0);
    check("rst_alu_opcode", {28'd0, alu_opcode}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Test 1: LOAD/ADD/STORE/HALT with zero-wait memory
    mem[12'h000] = 16'h7010;
    mem[12'h001] = 16'h1011;
    mem[12'h002] = 16'h8012;
    mem[12'h003] = 16'hF000;
    mem[12'h010] = 16'h0009;
    mem[12'h011] = 16'h0003;
    pulse_start();
    run("t1", cyc);
    check("t1_cycles", cyc, 32'd12);
    check("t1_store", {16'd0, mem[12'h012]}, 32'h000C);
    check("t1_acc", {16'd0, acc_out}, 32'h000C);
    check("t1_halted", {31'd0, halted}, 32'd1);
    check("t1_pc", {20'd0, pc_out}, 32'h004);
    check("t1_illegal", {31'd0, illegal}, 32'd0);

    // Test 2: each ALU op from ACC=9, MDR=3
    mem[12'h002] = 16'hF000;
    for (int k = 0; k < 5; k++) begin
      mem[12'h001] = {t2_op[k], 12'h011};
      pulse_start();
      run($sformatf("t2_op%0h", t2_op[k]), cyc);
      check($sformatf("t2_acc_op%0h", t2_op[k]), {16'd0, acc_out}, {16'd0, t2_exp[k]});
      check($sformatf("t2_cycles_op%0h", t2_op[k]), cyc, (t2_op[k] == 4'h6) ? 32'd8 : 32'd9);
    end

    // Test 3: JZ taken, JZ not taken, JMP
    mem[12'h000] = 16'h7013;
    mem[12'h001] = 16'hA020;
    mem[12'h002] = 16'hF000;
    mem[12'h013] = 16'h0000;
    mem[12'h020] = 16'hF000;
    mem[12'h030] = 16'hF000;
    pulse_start();
    run("t3_jz_taken", cyc);
    check("t3_jz_taken_pc", {20'd0, pc_out}, 32'h021);
    check("t3_jz_taken_cycles", cyc, 32'd7);
    mem[12'h013] = 16'h0001;
    pulse_start();
    run("t3_jz_not", cyc);
    check("t3_jz_not_pc", {20'd0, pc_out}, 32'h003);
    mem[12'h001] = 16'h9030;
    pulse_start();
    run("t3_jmp", cyc);
    check("t3_jmp_pc", {20'd0, pc_out}, 32'h031);

    // Test 4: program 1 with random wait states and stray acks between requests
    mem[12'h000] = 16'h7010;
    mem[12'h001] = 16'h1011;
    mem[12'h002] = 16'h8012;
    mem[12'h003] = 16'hF000;
    mem[12'h012] = 16'h0000;
    max_wait = 5;
    stray    = 1'b1;
    stab_err = 0;
    pulse_start();
    run("t4", cyc);
    check("t4_cycles_ge_min", {31'd0, cyc >= 12}, 32'd1);
    check("t4_store", {16'd0, mem[12'h012]}, 32'h000C);
    check("t4_acc", {16'd0, acc_out}, 32'h000C);
    check("t4_pc", {20'd0, pc_out}, 32'h004);
    check("t4_stable", stab_err, 32'd0);
    max_wait = 0;
    stray    = 1'b0;

    // Test 5: illegal opcode, then restart clears it
    mem[12'h000] = 16'hC000;
    pulse_start();
    run("t5", cyc);
    check("t5_illegal", {31'd0, illegal}, 32'd1);
    check("t5_halted", {31'd0, halted}, 32'd1);
    cyc = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req) cyc++;
      @(negedge clk);
    end
    check("t5_no_req", cyc, 32'd0);
    check("t5_illegal_held", {31'd0, illegal}, 32'd1);
    mem[12'h000] = 16'hF000;
    pulse_start();
    check("t5_restart_pc", {20'd0, pc_out}, 32'h000);
    check("t5_restart_illegal", {31'd0, illegal}, 32'd0);
    check("t5_restart_fetch_addr", {19'd0, mem_req, mem_addr}, 32'h1000);
    run("t5_restart", cyc);
    check("t5_restart_end_pc", {20'd0, pc_out}, 32'h001);

    // Test 6: reset asserted while a READ is stalled
    mem[12'h000] = 16'h7010;
    mem[12'h001] = 16'h1011;
    block_addr = 12'h011;
    block_en   = 1'b1;
    pulse_start();
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (mem_req && !mem_we && (mem_addr == 12'h011)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t6_read_reached", {31'd0, found}, 32'd1);
    repeat (2) @(negedge clk);
    check("t6_req_held", {19'd0, mem_req, mem_addr}, 32'h1011);
    check("t6_acc_before", {16'd0, acc_out}, 32'h0009);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req_dropped", {31'd0, mem_req}, 32'd0);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_halted", {31'd0, halted}, 32'd0);
    check("t6_acc", {16'd0, acc_out}, 32'd0);
    check("t6_pc", {20'd0, pc_out}, 32'd0);
    @(negedge clk);
    rst_n    = 1'b1;
    block_en = 1'b0;
    repeat (2) @(negedge clk);
    check("t6_idle_no_req", {30'd0, busy, mem_req}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
